// File: rtl/serial_axi_fifo_ctrl.sv
// AXI4-lite front end for the bit-level serializer: TX/RX word FIFOs, W1C sticky errors, level irq.
// Define SERIAL_FIFO_LOOPBACK_EN to build the internal TX->RX loopback selected by CONTROL[3].

module serial_axi_fifo_ctrl_fifo #(
   parameter int WIDTH      = 9,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  axi_clk,
   input  logic                  rst_b,
   input  logic                  flush,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  ovf
);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic                  do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign ovf     = push & full;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge axi_clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge axi_clk) begin
      if (!rst_b || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      count <= count + CNT_ONE;
         else if (!do_push && do_pop) count <= count - CNT_ONE;
      end
   end
endmodule

module serial_axi_fifo_ctrl #(
   parameter int DATA_WIDTH         = 9,
   parameter int DEPTH_LOG2         = 4,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [31:0]                   S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [31:0]                   S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   input  logic [DATA_WIDTH-1:0]         rx_data,
   input  logic                          rx_valid,
   output logic                          irq
);
   logic [DATA_WIDTH-1:0] rx_din, rx_dout;
   logic [DEPTH_LOG2:0]   tx_count, rx_count;
   logic                  tx_empty, tx_full, tx_ovf_hit, rx_empty, rx_full, rx_ovf_hit;
   logic                  tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush, rx_udf_hit;
   logic                  ctrl_enable, ctrl_loop_rd, loop_on, loop_move;
   logic                  rx_ovf, tx_ovf, rx_udf, rx_ie, tx_ie, err_ie;
   logic [7:0]            rx_thr, tx_thr;
   logic                  wr_en, rd_en, ctrl_wr, w1c_wr, start_wr;
   logic [1:0]            wr_sel, rd_sel;
   logic [31:0]           status_word, rd_mux;
   logic                  unused_ok;

   assign wr_en  = S_AXI_AWREADY;
   assign rd_en  = S_AXI_ARREADY;
   assign wr_sel = S_AXI_AWADDR[3:2];
   assign rd_sel = S_AXI_ARADDR[3:2];
   assign start_wr = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;

`ifdef SERIAL_FIFO_LOOPBACK_EN
   logic ctrl_loop;
   assign loop_on      = ctrl_enable & ctrl_loop;
   assign ctrl_loop_rd = ctrl_loop;
`else
   assign loop_on      = 1'b0;
   assign ctrl_loop_rd = 1'b0;
`endif

   assign loop_move = loop_on & ~tx_empty & ~rx_full;
   assign ctrl_wr   = wr_en & (wr_sel == 2'd2) & S_AXI_WSTRB[0];
   assign w1c_wr    = wr_en & (wr_sel == 2'd1) & S_AXI_WSTRB[0];
   assign tx_flush  = ctrl_wr & S_AXI_WDATA[1];
   assign rx_flush  = ctrl_wr & S_AXI_WDATA[2];

   assign tx_valid   = ctrl_enable & ~tx_empty & ~loop_on;
   assign tx_push    = wr_en & (wr_sel == 2'd0) & S_AXI_WSTRB[0];
   assign tx_pop     = (tx_valid & tx_ready) | loop_move;
   assign rx_push    = (rx_valid & ctrl_enable & ~loop_on) | loop_move;
   assign rx_din     = loop_on ? tx_data : rx_data;
   assign rx_pop     = rd_en & (rd_sel == 2'd0) & ~rx_empty;
   assign rx_udf_hit = rd_en & (rd_sel == 2'd0) & rx_empty;

   serial_axi_fifo_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .axi_clk(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .flush(tx_flush), .push(tx_push),
      .pop(tx_pop), .din(S_AXI_WDATA[DATA_WIDTH-1:0]), .dout(tx_data), .count(tx_count),
      .empty(tx_empty), .full(tx_full), .ovf(tx_ovf_hit));

   serial_axi_fifo_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .axi_clk(S_AXI_ACLK), .rst_b(S_AXI_ARESETN), .flush(rx_flush), .push(rx_push),
      .pop(rx_pop), .din(rx_din), .dout(rx_dout), .count(rx_count),
      .empty(rx_empty), .full(rx_full), .ovf(rx_ovf_hit));

   assign status_word = {8'h00, 8'(tx_count), 8'(rx_count), 1'b0, rx_udf, tx_ovf,
                         tx_full, tx_empty, rx_ovf, rx_full, rx_empty};

   always_comb begin
      rd_mux = '0;
      case (rd_sel)
         2'd0:    rd_mux = rx_empty ? '0 : 32'(rx_dout);
         2'd1:    rd_mux = status_word;
         2'd2:    rd_mux = {28'd0, ctrl_loop_rd, 2'b00, ctrl_enable};
         default: rd_mux = {13'd0, err_ie, tx_ie, rx_ie, tx_thr, rx_thr};
      endcase
   end

   assign S_AXI_BRESP = 2'b00;
   assign S_AXI_RRESP = 2'b00;

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         S_AXI_AWREADY <= start_wr;
         S_AXI_WREADY  <= start_wr;
         if (S_AXI_AWREADY)     S_AXI_BVALID <= 1'b1;
         else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         // RX pop is tied to the single ARREADY cycle, so a stalled RREADY never pops twice
         S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_ARREADY & ~S_AXI_RVALID;
         if (S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ctrl_enable <= 1'b0;
`ifdef SERIAL_FIFO_LOOPBACK_EN
         ctrl_loop   <= 1'b0;
`endif
         rx_thr <= '0;
         tx_thr <= '0;
         rx_ie  <= 1'b0;
         tx_ie  <= 1'b0;
         err_ie <= 1'b0;
         rx_ovf <= 1'b0;
         tx_ovf <= 1'b0;
         rx_udf <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            ctrl_enable <= S_AXI_WDATA[0];
`ifdef SERIAL_FIFO_LOOPBACK_EN
            ctrl_loop   <= S_AXI_WDATA[3];
`endif
         end
         if (wr_en && wr_sel == 2'd3) begin
            if (S_AXI_WSTRB[0]) rx_thr <= S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) tx_thr <= S_AXI_WDATA[15:8];
            if (S_AXI_WSTRB[2]) {err_ie, tx_ie, rx_ie} <= S_AXI_WDATA[18:16];
         end
         // a same-cycle set overrides the write-one-to-clear
         rx_ovf <= (rx_ovf & ~(w1c_wr & S_AXI_WDATA[2])) | rx_ovf_hit;
         tx_ovf <= (tx_ovf & ~(w1c_wr & S_AXI_WDATA[5])) | tx_ovf_hit;
         rx_udf <= (rx_udf & ~(w1c_wr & S_AXI_WDATA[6])) | rx_udf_hit;
         irq <= (rx_ie & (8'(rx_count) >= rx_thr) & ~rx_empty)
              | (tx_ie & (8'(tx_count) <= tx_thr))
              | (err_ie & (rx_ovf | tx_ovf | rx_udf));
      end
   end

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                        S_AXI_WDATA, S_AXI_WSTRB[3]};
endmodule

// File: tb/tb_serial_axi_fifo_ctrl.sv
// Randomized self-checking bench for serial_axi_fifo_ctrl against a queue-based register model.
module tb_serial_axi_fifo_ctrl;
   localparam int DW    = 9;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [3:0]    awaddr = '0, araddr = '0;
   logic [2:0]    awprot = '0, arprot = '0;
   logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic [DW-1:0] tx_data, rx_data = '0;
   logic          tx_valid, tx_ready = 0, rx_valid = 0, irq;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] m_tx[$], m_rx[$];
   bit            m_en, m_loop, m_rx_ovf, m_tx_ovf, m_rx_udf, m_rx_ie, m_tx_ie, m_err_ie;
   logic [7:0]    m_rx_thr, m_tx_thr;

   always #5 clk = ~clk;

   serial_axi_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH_LOG2(4), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq));

   // ---------------- reference model ----------------
   function automatic void m_reset();
      m_tx.delete(); m_rx.delete();
      m_en = 0; m_loop = 0; m_rx_ovf = 0; m_tx_ovf = 0; m_rx_udf = 0;
      m_rx_ie = 0; m_tx_ie = 0; m_err_ie = 0; m_rx_thr = '0; m_tx_thr = '0;
   endfunction

   function automatic void m_push_rx(input logic [DW-1:0] w);
      if (!m_en) return;
      if (m_rx.size() == DEPTH) m_rx_ovf = 1;
      else m_rx.push_back(w);
   endfunction

   function automatic void m_push_tx(input logic [DW-1:0] w);
      if (m_tx.size() == DEPTH) m_tx_ovf = 1;
      else m_tx.push_back(w);
      while (m_loop && m_en && m_tx.size() > 0 && m_rx.size() < DEPTH)
         m_rx.push_back(m_tx.pop_front());
   endfunction

   function automatic void m_apply_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      case (a[3:2])
         2'd0: if (s[0]) m_push_tx(d[DW-1:0]);
         2'd1: if (s[0]) begin
            if (d[2]) m_rx_ovf = 0;
            if (d[5]) m_tx_ovf = 0;
            if (d[6]) m_rx_udf = 0;
         end
         2'd2: if (s[0]) begin
            m_en = d[0];
            if (d[1]) m_tx.delete();
            if (d[2]) m_rx.delete();
`ifdef SERIAL_FIFO_LOOPBACK_EN
            m_loop = d[3];
`endif
         end
         default: begin
            if (s[0]) m_rx_thr = d[7:0];
            if (s[1]) m_tx_thr = d[15:8];
            if (s[2]) {m_err_ie, m_tx_ie, m_rx_ie} = d[18:16];
         end
      endcase
   endfunction

   function automatic logic [31:0] m_read_data();
      if (m_rx.size() == 0) begin
         m_rx_udf = 1;
         return 32'd0;
      end
      return 32'(m_rx.pop_front());
   endfunction

   function automatic logic [31:0] exp_status();
      return {8'h00, 8'(m_tx.size()), 8'(m_rx.size()), 1'b0, m_rx_udf, m_tx_ovf,
              m_tx.size() == DEPTH, m_tx.size() == 0, m_rx_ovf, m_rx.size() == DEPTH, m_rx.size() == 0};
   endfunction

   function automatic logic exp_irq();
      int rc, tc;
      rc = m_rx.size();
      tc = m_tx.size();
      return (m_rx_ie && rc >= int'(m_rx_thr) && rc != 0) || (m_tx_ie && tc <= int'(m_tx_thr)) ||
             (m_err_ie && (m_rx_ovf || m_tx_ovf || m_rx_udf));
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit rx_on_fire, input logic [DW-1:0] rx_w);
      int n = 0;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
      while (awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (awready !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL wr_awready_timeout addr=%h got awready=%b need 1", a, awready);
      end
      if (rx_on_fire) begin rx_valid = 1; rx_data = rx_w; end
      @(negedge clk);
      awvalid = 0; wvalid = 0; rx_valid = 0; bready = 1;
      n = 0;
      while (bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      vectors++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         miscompares++;
         $display("FAIL wr_bresp addr=%h got bvalid=%b bresp=%b need 1/00", a, bvalid, bresp);
      end
      @(negedge clk);
      bready = 0;
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      axi_write(a, d, s, 0, '0);
      m_apply_write(a, d, s);
   endtask

   task automatic reg_read(input logic [3:0] a, input int hold, output logic [31:0] d);
      int n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1;
      while (arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (arready !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL rd_arready_timeout addr=%h got arready=%b need 1", a, arready);
      end
      @(negedge clk);
      arvalid = 0;
      d = rdata;
      vectors++;
      if (rvalid !== 1'b1 || rresp !== 2'b00) begin
         miscompares++;
         $display("FAIL rd_rvalid addr=%h got rvalid=%b rresp=%b need 1/00", a, rvalid, rresp);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         vectors++;
         if (rvalid !== 1'b1 || rdata !== d) begin
            miscompares++;
            $display("FAIL rd_hold cycle=%0d got rvalid=%b rdata=%h need 1/%h", i, rvalid, rdata, d);
         end
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
   endtask

   task automatic push_rx(input logic [DW-1:0] w);
      @(negedge clk);
      rx_valid = 1; rx_data = w;
      m_push_rx(w);
      @(negedge clk);
      rx_valid = 0;
   endtask

   task automatic check_status(input string name);
      logic [31:0] d;
      logic [31:0] e;
      reg_read(4'h4, 0, d);
      e = exp_status();
      vectors++;
      if (d !== e) begin
         miscompares++;
         $display("FAIL %s got %h need %h", name, d, e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 0;
      repeat (3) @(negedge clk);
      resetn = 1;
      m_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      vectors++;
      if ({awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, irq, tx_valid} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got aw%b w%b b%b ar%b r%b rdata=%h irq=%b txv=%b need all 0",
                  awready, wready, bvalid, arready, rvalid, rdata, irq, tx_valid);
      end
      reg_read(4'h4, 0, d);
      vectors++;
      if (d !== 32'h0000_0009) begin
         miscompares++;
         $display("FAIL reset_status got %h need 00000009", d);
      end
      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h12; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
      repeat (3) @(negedge clk);
      awvalid = 0; wvalid = 0;
      vectors++;
      if (bvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_bvalid_before got %b need 1", bvalid);
      end
      resetn = 0;
      @(negedge clk);
      vectors++;
      if (bvalid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_bvalid_after got %b need 0", bvalid);
      end
      resetn = 1;
      m_reset();
      check_status("midreset_status");
   endtask

   task automatic test_tx_basic();
      reg_write(4'h8, 32'h1, 4'hF);
      reg_write(4'h0, 32'h1A5, 4'hF);
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== 9'h1A5) begin
         miscompares++;
         $display("FAIL tx_head got valid=%b data=%h need 1/1a5", tx_valid, tx_data);
      end
      tx_ready = 1;
      @(negedge clk);
      tx_ready = 0;
      void'(m_tx.pop_front());
      vectors++;
      if (tx_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL tx_after_pop got valid=%b need 0", tx_valid);
      end
      check_status("tx_drained_status");
      reg_write(4'h0, 32'h0FF, 4'hE);
      check_status("tx_wstrb0_ignored");
   endtask

   task automatic test_rx_fill();
      logic [31:0] d;
      for (int i = 1; i <= 17; i++) push_rx(DW'(i));
      reg_read(4'h4, 0, d);
      vectors++;
      if (d[15:8] !== 8'd16 || d[2:1] !== 2'b11 || d !== exp_status()) begin
         miscompares++;
         $display("FAIL rx_full_status got %h need %h", d, exp_status());
      end
      for (int i = 1; i <= 17; i++) begin
         logic [31:0] e;
         e = (i <= 16) ? 32'(i) : 32'd0;
         reg_read(4'h0, 0, d);
         void'(m_read_data());
         vectors++;
         if (d !== e) begin
            miscompares++;
            $display("FAIL rx_read_%0d got %h need %h", i, d, e);
         end
      end
      check_status("rx_udf_status");
   endtask

   task automatic test_w1c_set_wins();
      logic [31:0] d;
      reg_write(4'h4, 32'h64, 4'h1);
      check_status("w1c_clear_all");
      reg_read(4'h0, 0, d);
      void'(m_read_data());
      for (int i = 0; i < 17; i++) push_rx(DW'($urandom_range(0, 511)));
      check_status("w1c_pre_flags");
      axi_write(4'h4, 32'h64, 4'h1, 1, 9'h1FF);
      m_apply_write(4'h4, 32'h64, 4'h1);
      m_push_rx(9'h1FF);
      reg_read(4'h4, 0, d);
      vectors++;
      if (d[2] !== 1'b1 || d[6] !== 1'b0 || d !== exp_status()) begin
         miscompares++;
         $display("FAIL w1c_set_wins got %h need %h", d, exp_status());
      end
      reg_write(4'h4, 32'h04, 4'h1);
      check_status("w1c_ovf_cleared");
      reg_write(4'h8, 32'h5, 4'h1);
      check_status("rx_flush_status");
   endtask

   task automatic test_irq();
      logic [31:0] d;
      reg_write(4'hC, 32'h0001_0004, 4'hF);
      for (int i = 0; i < 3; i++) push_rx(DW'(8'h30 + i));
      repeat (2) @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_three_words got %b need 0", irq); end
      @(negedge clk);
      rx_valid = 1; rx_data = 9'h033; m_push_rx(9'h033);
      @(negedge clk);
      rx_valid = 0;
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_latency got %b need 0", irq); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_four_words got %b need 1", irq); end
      reg_read(4'h0, 0, d);
      vectors++;
      if (d !== m_read_data()) begin miscompares++; $display("FAIL irq_read_word got %h need 30", d); end
      @(negedge clk);
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_after_pop got %b need 0", irq); end
   endtask

   task automatic test_rready_hold();
      logic [31:0] d;
      logic [31:0] e;
      e = m_read_data();
      reg_read(4'h0, 5, d);
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL hold_rdata got %h need %h", d, e); end
      check_status("hold_single_pop");
   endtask

   task automatic test_tx_ovf_flush();
      reg_write(4'h8, 32'h0, 4'hF);
      for (int i = 0; i < 17; i++) reg_write(4'h0, 32'($urandom), 4'h1);
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_valid_disabled got %b need 0", tx_valid); end
      check_status("tx_full_ovf");
      reg_write(4'h8, 32'h3, 4'h1);
      check_status("tx_flush_keeps_flag");
   endtask

   task automatic test_loopback();
      logic [31:0] d;
`ifdef SERIAL_FIFO_LOOPBACK_EN
      reg_write(4'h8, 32'hF, 4'h1);
      reg_write(4'h0, 32'h055, 4'h1);
      reg_write(4'h0, 32'h0AA, 4'h1);
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL loop_tx_valid got %b need 0", tx_valid); end
      reg_read(4'h0, 0, d);
      vectors++;
      if (d !== 32'h055 || m_read_data() !== 32'h055) begin
         miscompares++; $display("FAIL loop_word0 got %h need 055", d);
      end
      reg_read(4'h0, 0, d);
      vectors++;
      if (d !== 32'h0AA || m_read_data() !== 32'h0AA) begin
         miscompares++; $display("FAIL loop_word1 got %h need 0aa", d);
      end
      reg_write(4'h8, 32'h1, 4'h1);
`else
      reg_write(4'h8, 32'h9, 4'h1);
      reg_read(4'h8, 0, d);
      vectors++;
      if (d !== 32'h1) begin miscompares++; $display("FAIL control_reserved got %h need 1", d); end
`endif
      check_status("loop_status");
   endtask

   task automatic test_random();
      logic [31:0] d, e;
      reg_write(4'h8, 32'h7, 4'h1);
      reg_write(4'h4, 32'h64, 4'h1);
      for (int op = 0; op < 200; op++) begin
         case ($urandom_range(0, 8))
            0, 1: begin
               int n = $urandom_range(1, 8);
               for (int i = 0; i < n; i++) begin
                  @(negedge clk);
                  rx_valid = ($urandom_range(0, 3) != 0);
                  rx_data = DW'($urandom);
                  if (rx_valid) m_push_rx(rx_data);
               end
               @(negedge clk);
               rx_valid = 0;
            end
            2: reg_write(4'h0, $urandom, 4'($urandom_range(0, 15)));
            3: begin
               int n = $urandom_range(1, 8);
               for (int i = 0; i < n; i++) begin
                  bit ev, rdy;
                  @(negedge clk);
                  ev = m_en && m_tx.size() > 0;
                  vectors++;
                  if (tx_valid !== ev || (ev && tx_data !== m_tx[0])) begin
                     miscompares++;
                     $display("FAIL rnd_tx got valid=%b data=%h need %b/%h", tx_valid, tx_data, ev,
                              ev ? m_tx[0] : '0);
                  end
                  rdy = 1'($urandom_range(0, 1));
                  tx_ready = rdy;
                  if (ev && rdy) void'(m_tx.pop_front());
               end
               @(negedge clk);
               tx_ready = 0;
            end
            4: begin
               e = m_read_data();
               reg_read(4'h0, $urandom_range(0, 2), d);
               vectors++;
               if (d !== e) begin miscompares++; $display("FAIL rnd_data got %h need %h", d, e); end
            end
            5: check_status("rnd_status");
            6: begin
               int r = $urandom_range(0, 15);
               reg_write(4'h8, {29'd0, r == 2, r == 1, r != 0}, 4'h1);
               reg_read(4'h8, 0, d);
               vectors++;
               if (d !== 32'(m_en)) begin miscompares++; $display("FAIL rnd_control got %h need %h", d, 32'(m_en)); end
            end
            7: begin
               int rt = $urandom_range(0, 17), tt = $urandom_range(0, 17), ie = $urandom_range(0, 7);
               reg_write(4'hC, {13'd0, 3'(ie), 8'(tt), 8'(rt)}, 4'($urandom_range(0, 15)));
               reg_read(4'hC, 0, d);
               e = {13'd0, m_err_ie, m_tx_ie, m_rx_ie, m_tx_thr, m_rx_thr};
               vectors++;
               if (d !== e) begin miscompares++; $display("FAIL rnd_irqcfg got %h need %h", d, e); end
            end
            default: reg_write(4'h4, {25'd0, 1'($urandom), 2'b00, 1'($urandom), 2'b00}, 4'($urandom_range(0, 15)));
         endcase
         repeat (2) @(negedge clk);
         vectors++;
         if (irq !== exp_irq()) begin
            miscompares++;
            $display("FAIL rnd_irq op=%0d got %b need %b", op, irq, exp_irq());
         end
      end
      check_status("rnd_final_status");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout need finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_reset();
      test_reset();
      test_tx_basic();
      test_rx_fill();
      test_w1c_set_wins();
      test_irq();
      test_rready_hold();
      test_tx_ovf_flush();
      test_loopback();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
